// File: rtl/k12a_spi_target_if.sv
// k12a_spi_target_if: SPI pins plus the local register-access port of the
// k12a SPI target, bundled so the target and its driver share one handle.
interface k12a_spi_target_if #(
    parameter int ADDR_BITS = 3
);
    logic                 spi_sck;
    logic                 spi_mosi;
    logic                 spi_cs_n;
    logic                 spi_miso;
    logic [ADDR_BITS-1:0] loc_addr;
    logic [7:0]           loc_rdata;
    logic                 loc_we;
    logic [7:0]           loc_wdata;
    logic                 spi_wr;
    logic [ADDR_BITS-1:0] spi_wr_addr;
    logic                 busy;

    // Driver side: SPI master pins and local-bus requests.
    modport master (
        output spi_sck, spi_mosi, spi_cs_n, loc_addr, loc_we, loc_wdata,
        input  spi_miso, loc_rdata, spi_wr, spi_wr_addr, busy
    );

    // Target side: the register-file responder.
    modport slave (
        input  spi_sck, spi_mosi, spi_cs_n, loc_addr, loc_we, loc_wdata,
        output spi_miso, loc_rdata, spi_wr, spi_wr_addr, busy
    );
endinterface

// File: rtl/k12a_spi_target.sv
// k12a_spi_target: SPI mode-0 responder exposing a byte-wide register file.
// SCK/MOSI/CS_N are oversampled on cpu_clock. First byte of a frame is a
// command (bit 7 = write, low bits = address); following bytes stream data
// with auto-incrementing, wrapping address. A local port shares the registers.
module k12a_spi_target #(
    parameter int          ADDR_BITS = 3,
    parameter logic [7:0]  REG_RESET = 8'h00
) (
    input  logic                cpu_clock,
    input  logic                reset,
    k12a_spi_target_if.slave    bus
);
    localparam int NUM_REGS = 2 ** ADDR_BITS;
    localparam logic [ADDR_BITS-1:0] ADDR_ONE = {{(ADDR_BITS-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, CMD, DATA} state_e;

    state_e               state_q, state_d;
    logic [1:0]           sck_sync_q, mosi_sync_q, cs_sync_q;
    logic                 sck_prev_q, cs_prev_q;
    logic [2:0]           bit_cnt_q, bit_cnt_d;
    logic [7:0]           rx_shift_q, rx_shift_d;
    logic [7:0]           tx_shift_q, tx_shift_d;
    logic                 rw_q, rw_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic                 miso_q, miso_d;
    logic                 spi_wr_q, spi_wr_d;
    logic [ADDR_BITS-1:0] spi_wr_addr_q, spi_wr_addr_d;
    logic [7:0]           regs_q [NUM_REGS];

    logic                 sck_s, mosi_s, cs_s;
    logic                 sck_rise, sck_fall, cs_fall, active, byte_done;
    logic                 spi_commit;
    logic [7:0]           rx_byte;
    logic [ADDR_BITS-1:0] next_addr;

    assign sck_s     = sck_sync_q[1];
    assign mosi_s    = mosi_sync_q[1];
    assign cs_s      = cs_sync_q[1];
    assign sck_rise  = sck_s & ~sck_prev_q;
    assign sck_fall  = ~sck_s & sck_prev_q;
    assign cs_fall   = cs_prev_q & ~cs_s;
    assign active    = (state_q != IDLE) && !cs_s;
    assign rx_byte   = {rx_shift_q[6:0], mosi_s};
    assign byte_done = active && sck_rise && (bit_cnt_q == 3'd7);
    assign next_addr = addr_q + ADDR_ONE;

    // Synchronizers and edge-detect history. CS_N stages reset low so a
    // select held low across reset never looks like a fresh falling edge.
    always_ff @(posedge cpu_clock or posedge reset) begin
        if (reset) begin
            sck_sync_q  <= 2'b00;
            mosi_sync_q <= 2'b00;
            cs_sync_q   <= 2'b00;
            sck_prev_q  <= 1'b0;
            cs_prev_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments let every flop sample pre-edge values, so the chain shifts one stage per clock.
            sck_sync_q  <= {sck_sync_q[0], bus.spi_sck};
            mosi_sync_q <= {mosi_sync_q[0], bus.spi_mosi};
            cs_sync_q   <= {cs_sync_q[0], bus.spi_cs_n};
            sck_prev_q  <= sck_s;
            cs_prev_q   <= cs_s;
        end
    end

    // FSM state register.
    always_ff @(posedge cpu_clock or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // FSM next state: arm on CS_N fall, command byte then data, drop on deselect.
    always_comb begin
        // NOTE: assigning a default first keeps every path covered, so no latch is inferred.
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (cs_fall) state_d = CMD;
            CMD:     if (cs_s) state_d = IDLE;
                     else if (byte_done) state_d = DATA;
            DATA:    if (cs_s) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs and datapath: shifting, command decode, commit, reload.
    always_comb begin
        bit_cnt_d     = bit_cnt_q;
        rx_shift_d    = rx_shift_q;
        tx_shift_d    = tx_shift_q;
        rw_d          = rw_q;
        addr_d        = addr_q;
        miso_d        = miso_q;
        spi_wr_d      = 1'b0;
        spi_wr_addr_d = spi_wr_addr_q;
        spi_commit    = 1'b0;
        if (!active) begin
            miso_d = 1'b0;
            if (state_q == IDLE && cs_fall) begin
                bit_cnt_d  = 3'd0;
                rx_shift_d = 8'h00;
            end
        end else begin
            if (sck_rise) begin
                rx_shift_d = rx_byte;
                bit_cnt_d  = bit_cnt_q + 3'd1;
            end
            if (sck_fall) begin
                if (state_q == DATA && !rw_q) begin
                    miso_d     = tx_shift_q[7];
                    tx_shift_d = {tx_shift_q[6:0], 1'b0};
                end else begin
                    miso_d = 1'b0;
                end
            end
            if (byte_done) begin
                if (state_q == CMD) begin
                    rw_d       = rx_byte[7];
                    addr_d     = rx_byte[ADDR_BITS-1:0];
                    tx_shift_d = rx_byte[7] ? 8'h00 : regs_q[rx_byte[ADDR_BITS-1:0]];
                end else if (rw_q) begin
                    spi_commit    = 1'b1;
                    spi_wr_d      = 1'b1;
                    spi_wr_addr_d = addr_q;
                    addr_d        = next_addr;
                end else begin
                    addr_d     = next_addr;
                    tx_shift_d = regs_q[next_addr];
                end
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge cpu_clock or posedge reset) begin
        if (reset) begin
            bit_cnt_q     <= 3'd0;
            rx_shift_q    <= 8'h00;
            tx_shift_q    <= 8'h00;
            rw_q          <= 1'b0;
            addr_q        <= '0;
            miso_q        <= 1'b0;
            spi_wr_q      <= 1'b0;
            spi_wr_addr_q <= '0;
        end else begin
            bit_cnt_q     <= bit_cnt_d;
            rx_shift_q    <= rx_shift_d;
            tx_shift_q    <= tx_shift_d;
            rw_q          <= rw_d;
            addr_q        <= addr_d;
            miso_q        <= miso_d;
            spi_wr_q      <= spi_wr_d;
            spi_wr_addr_q <= spi_wr_addr_d;
        end
    end

    // Register file: local write first, SPI commit last so SPI wins a same-address collision.
    always_ff @(posedge cpu_clock or posedge reset) begin
        if (reset) begin
            // NOTE: this register file has a defined reset value, so it is built from resettable flops, not a RAM macro.
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= REG_RESET;
        end else begin
            if (bus.loc_we) regs_q[bus.loc_addr] <= bus.loc_wdata;
            if (spi_commit) regs_q[addr_q] <= rx_byte;
        end
    end

    assign bus.spi_miso    = miso_q;
    assign bus.loc_rdata   = regs_q[bus.loc_addr];
    assign bus.spi_wr      = spi_wr_q;
    assign bus.spi_wr_addr = spi_wr_addr_q;
    assign bus.busy        = (state_q != IDLE);
endmodule
